// File: rtl/project_switch_sequencer_if.sv
// Wishbone slave bus bundle for the project switch sequencer.
// The master modport is the harness/CPU side; the slave modport is the controller.
interface project_switch_sequencer_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/project_switch_sequencer.sv
// Owns the active-project select and runs the blank/reset/release sequence
// around every project change, with optional timed auto-rotation.
module project_switch_sequencer #(
   parameter logic [31:0] BASE_ADDR    = 32'h30000800,
   parameter int unsigned NUM_PROJECTS = 5,
   parameter logic [15:0] GUARD_RESET  = 16'd16
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   project_switch_sequencer_if.slave    wbs,
   output logic [7:0]                   active_project,
   output logic                         oeb_force,
   output logic                         project_rst,
   output logic                         busy
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SETTLE, S_RELEASE} state_t;

   state_t      state_q, state_d;
   logic [15:0] phase_q, phase_d;
   logic [15:0] g_q, g_d;
   logic [7:0]  tgt_q, tgt_d;
   logic [7:0]  active_q, active_d;
   logic        pend_valid_q, pend_valid_d;
   logic [7:0]  pend_tgt_q, pend_tgt_d;
   logic        err_q, err_d;
   logic [15:0] guard_q, guard_d;
   logic        rot_en_q, rot_en_d;
   logic [23:0] dwell_q, dwell_d;
   logic [23:0] rot_cnt_q, rot_cnt_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_o_q, dat_o_d;
   logic        oeb_q, oeb_d;
   logic        prst_q, prst_d;
   logic        busy_q, busy_d;

   logic        access, in_win, wr, rd;
   logic [31:0] off;
   logic [1:0]  reg_sel;
   logic        req_wr, req_legal, guard_wr, rot_wr, rot_fire;
   logic [15:0] guard_eff;
   logic [7:0]  next_proj;
   logic [31:0] rdata;

   always_comb begin
      access    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
      off       = wbs.wbs_adr_i - BASE_ADDR;
      in_win    = off < 32'd12;
      reg_sel   = off[3:2];
      wr        = access & in_win & wbs.wbs_we_i;
      rd        = access & in_win & ~wbs.wbs_we_i;
      req_wr    = wr & (reg_sel == 2'd0) & wbs.wbs_sel_i[0];
      req_legal = req_wr & ({24'd0, wbs.wbs_dat_i[7:0]} < NUM_PROJECTS);
      guard_wr  = wr & (reg_sel == 2'd1) & (&wbs.wbs_sel_i[1:0]);
      rot_wr    = wr & (reg_sel == 2'd2) & (&wbs.wbs_sel_i);
      guard_eff = (guard_q == '0) ? 16'd1 : guard_q;
      next_proj = (32'(active_q) == NUM_PROJECTS - 1) ? '0 : active_q + 8'd1;
      // A same-cycle legal host request takes priority over the rotation trigger.
      rot_fire  = (state_q == S_IDLE) & rot_en_q & (dwell_q != '0) &
                  (rot_cnt_q == dwell_q - 24'd1) & ~req_legal;
      case (reg_sel)
         2'd0:    rdata = {14'd0, err_q, busy_q, pend_valid_q ? pend_tgt_q : 8'hFF, active_q};
         2'd1:    rdata = {16'd0, guard_q};
         2'd2:    rdata = {dwell_q, 7'd0, rot_en_q};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      g_d          = g_q;
      tgt_d        = tgt_q;
      active_d     = active_q;
      pend_valid_d = pend_valid_q;
      pend_tgt_d   = pend_tgt_q;
      err_d        = err_q;
      guard_d      = guard_q;
      rot_en_d     = rot_en_q;
      dwell_d      = dwell_q;

      case (state_q)
         S_IDLE: begin
            if (pend_valid_q || rot_fire) begin
               state_d      = S_DRAIN;
               g_d          = guard_eff;
               phase_d      = guard_eff - 16'd1;
               tgt_d        = pend_valid_q ? pend_tgt_q : next_proj;
               pend_valid_d = 1'b0;
            end
         end
         S_DRAIN: begin
            if (phase_q == '0) begin
               state_d  = S_SETTLE;
               phase_d  = g_q - 16'd1;
               active_d = tgt_q;
            end else begin
               phase_d = phase_q - 16'd1;
            end
         end
         S_SETTLE: begin
            if (phase_q == '0) state_d = S_RELEASE;
            else               phase_d = phase_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // A new request written while one is being launched replaces the pending slot.
      if (req_wr) begin
         if (req_legal) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = wbs.wbs_dat_i[7:0];
            err_d        = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      if (guard_wr) guard_d = wbs.wbs_dat_i[15:0];
      if (rot_wr) begin
         rot_en_d = wbs.wbs_dat_i[0];
         dwell_d  = wbs.wbs_dat_i[31:8];
      end

      rot_cnt_d = ((state_q == S_IDLE) && (state_d == S_IDLE) && rot_en_q &&
                   (dwell_q != '0) && !req_legal && !rot_wr) ? rot_cnt_q + 24'd1 : '0;

      busy_d  = state_d != S_IDLE;
      oeb_d   = state_d != S_IDLE;
      prst_d  = (state_d == S_DRAIN) || (state_d == S_SETTLE);
      ack_d   = access & in_win;
      dat_o_d = rd ? rdata : '0;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         g_q          <= 16'd1;
         tgt_q        <= '0;
         active_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_tgt_q   <= '0;
         err_q        <= 1'b0;
         guard_q      <= GUARD_RESET;
         rot_en_q     <= 1'b0;
         dwell_q      <= '0;
         rot_cnt_q    <= '0;
         ack_q        <= 1'b0;
         dat_o_q      <= '0;
         oeb_q        <= 1'b0;
         prst_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         g_q          <= g_d;
         tgt_q        <= tgt_d;
         active_q     <= active_d;
         pend_valid_q <= pend_valid_d;
         pend_tgt_q   <= pend_tgt_d;
         err_q        <= err_d;
         guard_q      <= guard_d;
         rot_en_q     <= rot_en_d;
         dwell_q      <= dwell_d;
         rot_cnt_q    <= rot_cnt_d;
         ack_q        <= ack_d;
         dat_o_q      <= dat_o_d;
         oeb_q        <= oeb_d;
         prst_q       <= prst_d;
         busy_q       <= busy_d;
      end
   end

   assign wbs.wbs_ack_o  = ack_q;
   assign wbs.wbs_dat_o  = dat_o_q;
   assign active_project = active_q;
   assign oeb_force      = oeb_q;
   assign project_rst    = prst_q;
   assign busy           = busy_q;

endmodule
